// File: rtl/gmii_frame_capture.sv
// Captures one GMII frame (octets after the SFD) into a local buffer,
// checks its FCS residue and holds it until software releases it.
//
// Handshake: frame_valid rises with frame_len/crc_ok/trunc/rx_err already
// settled and stays high, with those outputs and the buffer frozen, until
// frame_ack is sampled high; the release happens on that same edge.
// frame_ack while nothing is held has no effect.
module gmii_frame_capture #(
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    gmii_d,
  input  logic          gmii_en,
  input  logic          gmii_er,
  input  logic [aw-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          frame_ack,
  output logic          frame_valid,
  output logic [aw:0]   frame_len,
  output logic          crc_ok,
  output logic          trunc,
  output logic          rx_err,
  output logic [7:0]    drop_cnt,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {IDLE, PRE, DATA, HOLD, DROP} state_t;

  localparam logic [aw:0] max_cnt  = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] min_len  = (aw+1)'(5);
  localparam logic [31:0] crc_init = 32'hFFFF_FFFF;
  localparam logic [31:0] residue  = 32'hDEBB_20E3;

  state_t        state, state_d;
  logic          from_hold, from_hold_d;
  logic          en_q;
  logic [aw:0]   count;
  logic [31:0]   crc;
  logic [7:0]    mem [0:(1<<aw)-1];

  logic frame_start, sfd_seen, wr_en, trunc_set, err_set;
  logic close_frame, release_frame, drop_inc;

  assign state_dbg = state;

  // One octet of the reflected CRC-32 (LSB first, polynomial 0x04C11DB7).
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Next-state decode and one-cycle control strobes for the datapath.
  always_comb begin
    state_d       = state;
    from_hold_d   = from_hold;
    frame_start   = 1'b0;
    sfd_seen      = 1'b0;
    wr_en         = 1'b0;
    trunc_set     = 1'b0;
    err_set       = 1'b0;
    close_frame   = 1'b0;
    release_frame = 1'b0;
    drop_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_en) begin
          frame_start = 1'b1;
          from_hold_d = 1'b0;
          // en_q high here means the line was busy before reset released:
          // the tail of an abandoned frame, never a new capture.
          state_d = (gmii_d == 8'h55 && !en_q) ? PRE : DROP;
        end
      end
      PRE: begin
        if (!gmii_en) begin
          state_d = IDLE;
        end else begin
          err_set = gmii_er;
          if (gmii_d == 8'hD5) begin
            state_d  = DATA;
            sfd_seen = 1'b1;
          end else if (gmii_d != 8'h55) begin
            state_d = DROP;
          end
        end
      end
      DATA: begin
        if (gmii_en) begin
          err_set = gmii_er;
          if (count == max_cnt) trunc_set = 1'b1;
          else                  wr_en     = 1'b1;
        end else begin
          close_frame = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (frame_ack) release_frame = 1'b1;
        if (gmii_en) begin
          drop_inc    = 1'b1;
          state_d     = DROP;
          from_hold_d = !frame_ack;
        end else if (frame_ack) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (frame_ack && from_hold) begin
          release_frame = 1'b1;
          from_hold_d   = 1'b0;
        end
        if (!gmii_en) state_d = (from_hold && !frame_ack) ? HOLD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the held-frame marker and previous gmii_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      from_hold <= 1'b0;
      en_q      <= 1'b1;
    end else begin
      state     <= state_d;
      from_hold <= from_hold_d;
      en_q      <= gmii_en;
    end
  end

  // Frame datapath: count, CRC, status flags and the held-frame report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      crc         <= crc_init;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      crc_ok      <= 1'b0;
      trunc       <= 1'b0;
      rx_err      <= 1'b0;
      drop_cnt    <= 8'd0;
    end else begin
      if (frame_start) begin
        trunc  <= 1'b0;
        rx_err <= 1'b0;
      end
      if (err_set)   rx_err <= 1'b1;
      if (trunc_set) trunc  <= 1'b1;
      if (sfd_seen) begin
        count <= '0;
        crc   <= crc_init;
      end
      if (wr_en) begin
        count <= count + 1'b1;
        crc   <= crc_next(crc, gmii_d);
      end
      if (close_frame) begin
        frame_valid <= 1'b1;
        frame_len   <= count;
        crc_ok      <= (crc == residue) && (count >= min_len) && !trunc && !rx_err;
      end
      if (release_frame) frame_valid <= 1'b0;
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[aw-1:0]] <= gmii_d;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'd0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_gmii_frame_capture.sv
// Bench for gmii_frame_capture: frame-level reference model, directed
// scenarios, randomized frames and a per-cycle compare process.
module tb_gmii_frame_capture;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  logic [7:0]    gmii_d = 8'd0;
  logic          gmii_en = 1'b0;
  logic          gmii_er = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          frame_ack = 1'b0;
  logic          frame_valid;
  logic [AW:0]   frame_len;
  logic          crc_ok, trunc, rx_err;
  logic [7:0]    drop_cnt;
  logic [2:0]    state_dbg;

  gmii_frame_capture #(.aw(AW)) dut (
    .clk(clk), .rst_n(rst_n), .gmii_d(gmii_d), .gmii_en(gmii_en), .gmii_er(gmii_er),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ack(frame_ack),
    .frame_valid(frame_valid), .frame_len(frame_len), .crc_ok(crc_ok),
    .trunc(trunc), .rx_err(rx_err), .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic       m_valid  = 1'b0;
  int         m_len    = 0;
  logic       m_crc_ok = 1'b0;
  logic       m_trunc  = 1'b0;
  logic       m_err    = 1'b0;
  int         m_drop   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] fr_q[$];
  logic [7:0] pay_q[$];

  logic [AW-1:0] rd_q_addr = '0;
  logic          rd_q_chk  = 1'b0;
  bit            sweep_en  = 1'b0;
  int            sweep_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // FCS of the n-4 leading data octets must equal the trailing 4 octets.
  function automatic bit fcs_ok(input int first, input int n);
    logic [31:0] c;
    logic [31:0] fcs;
    c = 32'hFFFF_FFFF;
    for (int j = 0; j < n - 4; j++) c = crc_byte(c, fr_q[first + j]);
    fcs = ~c;
    return fr_q[first+n-4] == fcs[7:0]   && fr_q[first+n-3] == fcs[15:8] &&
           fr_q[first+n-2] == fcs[23:16] && fr_q[first+n-1] == fcs[31:24];
  endfunction

  // fr_q = pre_len x 0x55, 0xD5, pay_q, FCS(pay_q)
  task automatic build_frame(input int pre_len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    fr_q.delete();
    repeat (pre_len) fr_q.push_back(8'h55);
    fr_q.push_back(8'hD5);
    foreach (pay_q[j]) begin
      fr_q.push_back(pay_q[j]);
      c = crc_byte(c, pay_q[j]);
    end
    c = ~c;
    fr_q.push_back(c[7:0]);
    fr_q.push_back(c[15:8]);
    fr_q.push_back(c[23:16]);
    fr_q.push_back(c[31:24]);
  endtask

  // What a frame received while nothing is held leaves in the buffer.
  task automatic model_capture(input int er_idx);
    int k;
    int n;
    if (fr_q.size() < 2 || fr_q[0] != 8'h55) return;
    k = -1;
    for (int i = 1; i < fr_q.size(); i++) begin
      if (fr_q[i] == 8'hD5) begin
        k = i;
        break;
      end else if (fr_q[i] != 8'h55) begin
        break;
      end
    end
    if (k < 0) return;
    n = fr_q.size() - k - 1;
    exp_q.delete();
    for (int j = 0; j < n && j < DEPTH; j++) exp_q.push_back(fr_q[k+1+j]);
    m_len    = exp_q.size();
    m_trunc  = (n > DEPTH);
    m_err    = (er_idx >= 1 && er_idx < fr_q.size());
    m_crc_ok = !m_trunc && !m_err && (n >= 5) && fcs_ok(k + 1, n);
    m_valid  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    gmii_en = 1'b0;
    gmii_er = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    tick();
    if (m_valid) m_valid = 1'b0;
    frame_ack = 1'b0;
  endtask

  // Drives fr_q; er/ack/reset land on the given octet index (-1 = none).
  task automatic send_frame(input int er_idx, input int ack_idx, input int rst_idx);
    bit held;
    held = m_valid;
    for (int i = 0; i < fr_q.size(); i++) begin
      gmii_en   = 1'b1;
      gmii_d    = fr_q[i];
      gmii_er   = (i == er_idx);
      frame_ack = (i == ack_idx);
      if (i == rst_idx) begin
        rst_n = 1'b0;
        #1;
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_flags", {29'd0, crc_ok, trunc, rx_err}, 32'd0);
        m_valid = 1'b0;
        m_drop  = 0;
        m_len   = 0;
      end
      tick();
      if (i == rst_idx) rst_n = 1'b1;
      if (i == 0 && held) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      if (i == ack_idx && m_valid) m_valid = 1'b0;
    end
    gmii_en   = 1'b0;
    gmii_er   = 1'b0;
    frame_ack = 1'b0;
    gmii_d    = 8'd0;
    tick();
    if (!held && rst_idx < 0) model_capture(er_idx);
  endtask

  task automatic sweep(input int n);
    sweep_ptr = 0;
    sweep_en  = 1'b1;
    repeat (n) tick();
    sweep_en  = 1'b0;
  endtask

  // read-address driver: sequential sweep or random within the held frame
  initial forever begin
    @(posedge clk);
    #1;
    if (sweep_en) begin
      rd_addr   = AW'(sweep_ptr);
      sweep_ptr = sweep_ptr + 1;
    end else if (m_valid && m_len > 0) begin
      rd_addr = AW'($urandom_range(0, m_len - 1));
    end else begin
      rd_addr = AW'($urandom);
    end
  end

  // remember which address the DUT sampled and whether its data is defined
  always @(posedge clk) begin
    rd_q_addr <= rd_addr;
    rd_q_chk  <= rst_n && m_valid && (int'(rd_addr) < m_len);
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    check("frame_valid", 32'(frame_valid), 32'(m_valid));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("state_dbg_known", 32'($isunknown(state_dbg)), 32'd0);
    if (m_valid) begin
      check("frame_len", 32'(frame_len), 32'(m_len));
      check("crc_ok", 32'(crc_ok), 32'(m_crc_ok));
      check("trunc", 32'(trunc), 32'(m_trunc));
      check("rx_err", 32'(rx_err), 32'(m_err));
    end
    if (!rst_n) check("rd_data_rst", 32'(rd_data), 32'd0);
    else if (rd_q_chk) check("rd_data", 32'(rd_data), 32'(exp_q[rd_q_addr]));
  end

  task automatic std_payload(input int n);
    pay_q.delete();
    for (int j = 0; j < n; j++) pay_q.push_back(8'(j * 7 + 3));
    if (n > 10) pay_q[10] = 8'h00;
  endtask

  initial begin
    logic [31:0] c;
    int pl, pre, mode, er, ack, r;

    // model pin: CRC-32 of "123456789" is 0xCBF43926
    c = 32'hFFFF_FFFF;
    for (int j = 0; j < 9; j++) c = crc_byte(c, 8'(8'h31 + j));
    check("crc_model_pin", ~c, 32'hCBF4_3926);

    repeat (3) tick();
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_frame_len", 32'(frame_len), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // good 64-octet frame, read back all of it
    std_payload(60);
    build_frame(7);
    send_frame(-1, -1, -1);
    check("good_valid", 32'(frame_valid), 32'd1);
    check("good_len", 32'(frame_len), 32'd64);
    check("good_crc_ok", 32'(crc_ok), 32'd1);
    sweep(66);
    do_ack();
    idle(2);

    // payload octet 10 flipped 0x00 -> 0x01
    std_payload(60);
    build_frame(7);
    fr_q[8+10] = 8'h01;
    send_frame(-1, -1, -1);
    check("flip_len", 32'(frame_len), 32'd64);
    check("flip_crc_ok", 32'(crc_ok), 32'd0);
    do_ack();
    idle(2);

    // frame while holding is dropped, held frame untouched
    std_payload(60);
    build_frame(7);
    send_frame(-1, -1, -1);
    for (int j = 0; j < 60; j++) pay_q[j] = 8'($urandom);
    build_frame(7);
    send_frame(-1, -1, -1);
    check("drop_one", 32'(drop_cnt), 32'd1);
    check("drop_len_kept", 32'(frame_len), 32'd64);
    sweep(66);
    do_ack();
    idle(2);
    std_payload(60);
    build_frame(7);
    send_frame(-1, -1, -1);
    check("third_crc_ok", 32'(crc_ok), 32'd1);

    // ack on the first octet of a new frame, then ack mid-drop
    build_frame(3);
    send_frame(-1, 0, -1);
    check("ack_start_valid", 32'(frame_valid), 32'd0);
    check("ack_start_drop", 32'(drop_cnt), 32'd2);
    idle(2);
    build_frame(7);
    send_frame(-1, -1, -1);
    build_frame(7);
    send_frame(-1, 20, -1);
    check("ack_mid_drop_valid", 32'(frame_valid), 32'd0);
    idle(2);

    // oversize frame truncates at 1024
    pay_q.delete();
    repeat (1096) pay_q.push_back(8'($urandom));
    build_frame(7);
    send_frame(-1, -1, -1);
    check("long_len", 32'(frame_len), 32'd1024);
    check("long_trunc", 32'(trunc), 32'd1);
    check("long_crc_ok", 32'(crc_ok), 32'd0);
    repeat (40) tick();
    do_ack();
    idle(2);

    // bad SFD, then gmii_er mid-payload
    std_payload(60);
    build_frame(7);
    fr_q[7] = 8'hD4;
    send_frame(-1, -1, -1);
    check("bad_sfd_valid", 32'(frame_valid), 32'd0);
    idle(2);
    build_frame(7);
    send_frame(8 + 30, -1, -1);
    check("er_rx_err", 32'(rx_err), 32'd1);
    check("er_crc_ok", 32'(crc_ok), 32'd0);
    do_ack();
    idle(2);

    // length boundary: 4 octets cannot pass, 5 can
    pay_q.delete();
    build_frame(2);
    send_frame(-1, -1, -1);
    check("len4_crc_ok", 32'(crc_ok), 32'd0);
    do_ack();
    idle(1);
    pay_q.push_back(8'hA5);
    build_frame(2);
    send_frame(-1, -1, -1);
    check("len5_crc_ok", 32'(crc_ok), 32'd1);
    do_ack();
    idle(1);

    // reset in the middle of payload octet 20, then recover
    std_payload(60);
    build_frame(7);
    send_frame(-1, -1, 8 + 20);
    check("rst_no_valid", 32'(frame_valid), 32'd0);
    idle(2);
    build_frame(7);
    send_frame(-1, -1, -1);
    check("post_rst_crc_ok", 32'(crc_ok), 32'd1);
    do_ack();
    idle(2);

    // randomized frames, errors and ack timing
    for (int it = 0; it < 40; it++) begin
      pl   = $urandom_range(0, 80);
      pre  = $urandom_range(1, 7);
      mode = $urandom_range(0, 7);
      pay_q.delete();
      repeat (pl) pay_q.push_back(8'($urandom));
      build_frame(pre);
      er  = -1;
      ack = -1;
      if (mode == 0)      fr_q[pre] = 8'hD4;
      else if (mode == 1) fr_q[fr_q.size()-1] = fr_q[fr_q.size()-1] ^ 8'h01;
      else if (mode == 2) er = pre + 1 + $urandom_range(0, pl + 3);
      if (m_valid) begin
        r = $urandom_range(0, 2);
        if (r == 0)      ack = 0;
        else if (r == 1) ack = $urandom_range(1, fr_q.size() - 1);
      end
      send_frame(er, ack, -1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 6)) tick();
        do_ack();
      end
      idle($urandom_range(1, 3));
    end

    // drop counter saturation
    do_ack();
    idle(1);
    std_payload(20);
    build_frame(7);
    send_frame(-1, -1, -1);
    for (int it = 0; it < 258; it++) begin
      fr_q.delete();
      fr_q.push_back(8'h55);
      fr_q.push_back(8'h55);
      send_frame(-1, -1, -1);
      idle(1);
    end
    check("drop_sat", 32'(drop_cnt), 32'd255);
    check("sat_still_valid", 32'(frame_valid), 32'd1);
    do_ack();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
